// File: rtl/game_round_controller.sv
// Round sequencer for the screen win-detect game: clear, count moves, check for an all-zero screen, buzz, report.
// Optional round time limit is enabled with the ROUND_TIMEOUT_EN macro.
module game_round_controller #(
  parameter int unsigned NumberOfBits = 31,
  parameter int unsigned MAX_MOVES    = 63,
  parameter int unsigned MOVE_W       = 6,
  parameter int unsigned BUZZ_CYCLES  = 25000000,
  parameter int unsigned BUZZ_W       = 25,
  parameter int unsigned ROUND_CYCLES = 500000000,
  parameter int unsigned ROUND_W      = 29
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  move_valid,
  input  logic [NumberOfBits:0] ScreenValues,
  output logic                  clear_screen,
  output logic                  round_active,
  output logic                  Buzz,
  output logic                  win,
  output logic                  lose,
  output logic [MOVE_W-1:0]     move_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, PLAY, CHECK, WIN, LOSE, DONE} state_t;

  localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYCLES - 1);
  localparam logic [MOVE_W-1:0] MOVE_MAX  = MOVE_W'(MAX_MOVES);

  // Reject parameter sets whose counters cannot hold their limits.
  if (BUZZ_CYCLES < 1 || (64'(1) << BUZZ_W) < 64'(BUZZ_CYCLES) ||
      (64'(1) << MOVE_W) <= 64'(MAX_MOVES) || (64'(1) << ROUND_W) < 64'(ROUND_CYCLES)) begin : g_bad_params
    $error("game_round_controller: counter widths too small for configured limits");
  end

  state_t            state;
  logic [BUZZ_W-1:0] buzz_timer;
  logic [BUZZ_W-1:0] buzz_inc;
  logic              screen_clear;
  logic              expired;

  assign buzz_inc     = buzz_timer + BUZZ_W'(1);
  assign screen_clear = (ScreenValues == '0);

`ifdef ROUND_TIMEOUT_EN
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUND_CYCLES - 1);
  logic [ROUND_W-1:0] round_timer;

  // Round timer runs only while the round is live and parks at its last value.
  always_ff @(posedge clk) begin
    if (!reset || state == CLEAR) begin
      round_timer <= '0;
    end else if ((state == PLAY || state == CHECK) && round_timer != ROUND_LAST) begin
      round_timer <= round_timer + ROUND_W'(1);
    end
  end

  assign expired = (round_timer == ROUND_LAST);
`else
  assign expired = 1'b0;
`endif

  // Round sequencer; outputs are loaded on the transition into each state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      clear_screen <= 1'b0;
      round_active <= 1'b0;
      Buzz         <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      move_count   <= '0;
      buzz_timer   <= '0;
    end else begin
      clear_screen <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= CLEAR;
            clear_screen <= 1'b1;
            win          <= 1'b0;
            lose         <= 1'b0;
            move_count   <= '0;
            buzz_timer   <= '0;
          end
        end
        CLEAR: begin
          state        <= PLAY;
          round_active <= 1'b1;
        end
        PLAY: begin
          if (move_valid) begin
            state <= CHECK;
            if (move_count != MOVE_MAX) move_count <= move_count + MOVE_W'(1);
          end else if (expired) begin
            state        <= LOSE;
            round_active <= 1'b0;
            lose         <= 1'b1;
            Buzz         <= 1'b0;
            buzz_timer   <= '0;
          end
        end
        CHECK: begin
          // A cleared screen wins even on the final move or after the time limit.
          if (screen_clear) begin
            state        <= WIN;
            round_active <= 1'b0;
            win          <= 1'b1;
            Buzz         <= 1'b1;
            buzz_timer   <= '0;
          end else if (move_count == MOVE_MAX || expired) begin
            state        <= LOSE;
            round_active <= 1'b0;
            lose         <= 1'b1;
            Buzz         <= 1'b0;
            buzz_timer   <= '0;
          end else begin
            state <= PLAY;
          end
        end
        WIN, LOSE: begin
          if (buzz_timer == BUZZ_LAST) begin
            state <= DONE;
            Buzz  <= 1'b0;
          end else begin
            buzz_timer <= buzz_inc;
            Buzz       <= (state == WIN) || buzz_inc[BUZZ_W-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Randomized round-level bench for game_round_controller with a transaction-level outcome model.
module tb_game_round_controller;

  localparam int unsigned NB = 7;
  localparam int unsigned MAXM = 3;
  localparam int unsigned MW = 2;
  localparam int unsigned BC = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned RC = 20;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          move_valid = 1'b0;
  logic [NB:0]   ScreenValues = '1;
  logic          clear_screen;
  logic          round_active;
  logic          Buzz;
  logic          win;
  logic          lose;
  logic [MW-1:0] move_count;

  int n_tests = 0;
  int n_fail  = 0;

  game_round_controller #(
    .NumberOfBits(NB), .MAX_MOVES(MAXM), .MOVE_W(MW), .BUZZ_CYCLES(BC),
    .BUZZ_W(BW), .ROUND_CYCLES(RC), .ROUND_W(RW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .ScreenValues(ScreenValues), .clear_screen(clear_screen), .round_active(round_active),
    .Buzz(Buzz), .win(win), .lose(lose), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input bit cs, input bit ra, input bit bz,
                          input bit w, input bit l, input int mc);
    chk({tag, ".clear_screen"}, 32'(clear_screen), 32'(cs));
    chk({tag, ".round_active"}, 32'(round_active), 32'(ra));
    chk({tag, ".buzz"}, 32'(Buzz), 32'(bz));
    chk({tag, ".win"}, 32'(win), 32'(w));
    chk({tag, ".lose"}, 32'(lose), 32'(l));
    chk({tag, ".move_count"}, 32'(move_count), 32'(mc));
  endtask

  // Expected lose buzz: high during the second half of the result phase.
  function automatic bit lose_buzz(input int t);
    return t >= (1 << (BW - 1));
  endfunction

  // One round from IDLE/DONE; win_move selects the move whose checked screen is all zero (0 = never).
  task automatic run_round(input int win_move);
    int  moves = 0;
    bit  won = 1'b0;
    int  idle;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear.cs", 32'(clear_screen), 32'd1);
    chk("clear.ra", 32'(round_active), 32'd0);
    step();
    chk_outs("play0", 0, 1, 0, 0, 0, 0);
    forever begin
      idle = $urandom_range(0, 3);
      repeat (idle) begin
        move_valid   = 1'b0;
        start        = 1'($urandom_range(0, 1));
        ScreenValues = NB'($urandom_range(0, 1)) == '0 ? '0 : (NB+1)'($urandom_range(0, 255));
        step();
        chk_outs("idle", 0, 1, 0, 0, 0, moves);
      end
      start        = 1'($urandom_range(0, 1));
      ScreenValues = (NB+1)'($urandom_range(1, 255));
      move_valid   = 1'b1;
      step();
      if (moves < int'(MAXM)) moves++;
      start = 1'b0;
      chk_outs("check", 0, 1, 0, 0, 0, moves);
      move_valid   = 1'($urandom_range(0, 1));
      ScreenValues = (moves == win_move) ? '0 : (NB+1)'($urandom_range(1, 255));
      step();
      move_valid = 1'b0;
      if (moves == win_move) begin
        won = 1'b1;
        break;
      end
      if (moves == int'(MAXM)) break;
      chk_outs("back", 0, 1, 0, 0, 0, moves);
    end
    for (int t = 0; t < int'(BC); t++) begin
      chk_outs(won ? "win" : "lose", 0, 0, won ? 1'b1 : lose_buzz(t), won, !won, moves);
      start = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    chk_outs("done", 0, 0, 0, won, !won, moves);
    step();
    chk_outs("done.hold", 0, 0, 0, won, !won, moves);
  endtask

  initial begin
    reset = 1'b0;
    step();
    step();
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    chk_outs("idle_ignores", 0, 0, 0, 0, 0, 0);

    run_round(1);
    run_round(0);
    for (int r = 0; r < 25; r++) run_round($urandom_range(0, MAXM));

    // Reset asserted in the middle of the win buzz.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    ScreenValues = 8'h01;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    ScreenValues = 8'h00;
    step();
    chk_outs("midwin", 0, 0, 1, 1, 0, 1);
    step();
    reset = 1'b0;
    step();
    chk_outs("reset_in_win", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    ScreenValues = '1;
    step();
    chk_outs("after_reset", 0, 0, 0, 0, 0, 0);
    run_round(2);

`ifdef ROUND_TIMEOUT_EN
    // No moves: lose after exactly RC live cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 1; i < int'(RC); i++) begin
      step();
      chk_outs("to_wait", 0, 1, 0, 0, 0, 0);
    end
    step();
    chk_outs("to_lose", 0, 0, 0, 0, 1, 0);
    repeat (BC) step();
    chk_outs("to_done", 0, 0, 0, 0, 1, 0);

    // Move on the expiry cycle with a cleared screen still wins.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (RC - 1) step();
    ScreenValues = 8'h5A;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    chk_outs("to_check", 0, 1, 0, 0, 0, 1);
    ScreenValues = 8'h00;
    step();
    chk_outs("to_win", 0, 0, 1, 1, 0, 1);
    repeat (BC) step();
    chk_outs("to_win_done", 0, 0, 0, 1, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
